axi_lite_fb_write_slave: RTL

//  AXI4-Lite write-channel responder. Terminates the accelerator's master write port.

---
 rtl/axi_lite_fb_write_slave_if.sv | 28 ++
 rtl/axi_lite_fb_write_slave.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axi_lite_fb_write_slave_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between the accelerator master
// and the framebuffer write slave.
interface axi_lite_fb_write_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/axi_lite_fb_write_slave.sv
// AXI4-Lite write responder committing byte-enabled writes into a word-addressed
// framebuffer RAM, with a 1-cycle synchronous display read port.
module axi_lite_fb_write_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 48,
  localparam int RD_AW     = $clog2(MEM_DEPTH)
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_lite_fb_write_slave_if.slave s_axi,
  input  logic [RD_AW-1:0]       RD_ADDR,
  output logic [DATA_WIDTH-1:0]  RD_DATA,
  output logic [15:0]            WR_COUNT
);

  localparam int          STRB_W   = DATA_WIDTH / 8;
  localparam int          BYTE_LSB = $clog2(STRB_W);
  localparam int          IDX_W    = ADDR_WIDTH - BYTE_LSB;
  localparam logic [31:0] DEPTH_U  = MEM_DEPTH;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_aw_held, w_aw_held_nxt;
  logic                  r_w_held, w_w_held_nxt;
  logic                  r_awready, w_awready_nxt;
  logic                  r_wready, w_wready_nxt;
  logic                  r_bvalid, w_bvalid_nxt;
  logic [1:0]            r_bresp, w_bresp_nxt;
  logic [15:0]           r_wr_count, w_wr_count_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic w_aw_hs, w_w_hs, w_in_range, w_commit_we;
  logic w_unused_prot;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // READY is only ever high in IDLE, so a handshake implies IDLE.
  assign w_aw_hs       = s_axi.AWVALID & r_awready;
  assign w_w_hs        = s_axi.WVALID & r_wready;
  assign w_in_range    = 32'(r_idx) < DEPTH_U;
  assign w_unused_prot = ^s_axi.AWPROT;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_aw_held_nxt  = r_aw_held;
    w_w_held_nxt   = r_w_held;
    w_awready_nxt  = 1'b0;
    w_wready_nxt   = 1'b0;
    w_bvalid_nxt   = r_bvalid;
    w_bresp_nxt    = r_bresp;
    w_wr_count_nxt = r_wr_count;
    w_commit_we    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_aw_held_nxt = r_aw_held | w_aw_hs;
        w_w_held_nxt  = r_w_held | w_w_hs;
        if (r_aw_held && r_w_held) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_awready_nxt = ~w_aw_held_nxt;
          w_wready_nxt  = ~w_w_held_nxt;
        end
      end
      S_COMMIT: begin
        w_bvalid_nxt = 1'b1;
        w_state_nxt  = S_RESP;
        if (w_in_range) begin
          w_commit_we    = 1'b1;
          w_bresp_nxt    = RESP_OKAY;
          w_wr_count_nxt = r_wr_count + 16'd1;
        end else begin
          w_bresp_nxt = RESP_SLVERR;
        end
      end
      S_RESP: begin
        if (s_axi.BREADY) begin
          w_bvalid_nxt  = 1'b0;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= S_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_count <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_aw_held  <= w_aw_held_nxt;
      r_w_held   <= w_w_held_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_bresp    <= w_bresp_nxt;
      r_wr_count <= w_wr_count_nxt;
      if (w_aw_hs) r_idx <= s_axi.AWADDR[ADDR_WIDTH-1:BYTE_LSB];
      if (w_w_hs) begin
        r_wdata <= s_axi.WDATA;
        r_wstrb <= s_axi.WSTRB;
      end
    end
  end

  // NOTE: the RAM has no reset so it maps onto block memory and keeps its
  // contents across ARESETn; an abandoned COMMIT never raises the write enable.
  always_ff @(posedge ACLK) begin
    if (w_commit_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (r_wstrb[i]) mem[r_idx[RD_AW-1:0]][i*8 +: 8] <= r_wdata[i*8 +: 8];
      end
    end
  end

  // Reads see the pre-edge word, so a same-edge write returns old data.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rd_data <= '0;
    end else if (32'(RD_ADDR) < DEPTH_U) begin
      r_rd_data <= mem[RD_ADDR];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign RD_DATA       = r_rd_data;
  assign WR_COUNT      = r_wr_count;

endmodule
